// File: rtl/adder32_share_arbiter.sv
// adder32_share_arbiter: one 32-bit adder shared by NUM_REQ requesters, round-robin.
// Optional signed-overflow output is enabled with `define ADDER32_ARB_OVF_EN.

module adder32_fa #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  // plain ripple-free behavioural add; carry-out is the extra top bit
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
endmodule

module adder32_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_cin,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_cout,
  output logic [ID_W-1:0]          rsp_id
`ifdef ADDER32_ARB_OVF_EN
  ,
  output logic                     rsp_ovf
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] gidx;
  logic            gnt;
  logic            can_accept;
  logic            fire;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic             cin_sel;
  logic [WIDTH-1:0] sum_w;
  logic             cout_w;

  // first valid requester at or after rr_ptr, wrapping
  always_comb begin
    gnt  = 1'b0;
    gidx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int j;
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!gnt && req_valid[j]) begin
        gnt  = 1'b1;
        gidx = ID_W'(j);
      end
    end
  end

  assign can_accept = (state == EMPTY) | rsp_ready;
  assign fire       = gnt & can_accept & ~rst;
  assign req_ready  = fire ? (NUM_REQ'(1) << gidx) : '0;
  assign rsp_valid  = (state == FULL);

  assign a_sel   = req_a[int'(gidx)*WIDTH +: WIDTH];
  assign b_sel   = req_b[int'(gidx)*WIDTH +: WIDTH];
  assign cin_sel = req_cin[gidx];

  adder32_fa #(
    .WIDTH (WIDTH)
  ) u_fa (
    .a    (a_sel),
    .b    (b_sel),
    .cin  (cin_sel),
    .sum  (sum_w),
    .cout (cout_w)
  );

`ifdef ADDER32_ARB_OVF_EN
  logic ovf_w;
  assign ovf_w = (a_sel[WIDTH-1] == b_sel[WIDTH-1]) &&
                 (sum_w[WIDTH-1] != a_sel[WIDTH-1]);

  // overflow flag travels with the result it belongs to
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rsp_ovf <= 1'b0;
    else if (fire) rsp_ovf <= ovf_w;
  end
`endif

  // slot FSM, result registers and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= EMPTY;
      rr_ptr   <= '0;
      rsp_sum  <= '0;
      rsp_cout <= 1'b0;
      rsp_id   <= '0;
    end else begin
      if (fire) begin
        rsp_sum  <= sum_w;
        rsp_cout <= cout_w;
        rsp_id   <= gidx;
        rr_ptr   <= (int'(gidx) == NUM_REQ - 1) ? '0 : gidx + 1'b1;
      end
      unique case (state)
        EMPTY: if (fire) state <= FULL;
        FULL:  if (rsp_ready && !fire) state <= EMPTY;
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_adder32_share_arbiter.sv
// tb_adder32_share_arbiter: directed steps plus a random handshake scoreboard.
// Expected values are hand-computed or derived from the bench's own operands.

module tb_adder32_share_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic [N-1:0]   req_cin = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [W-1:0]   rsp_sum;
  logic           rsp_cout;
  logic [1:0]     rsp_id;
`ifdef ADDER32_ARB_OVF_EN
  logic           rsp_ovf;
`endif

  int total = 0;
  int bad   = 0;

  adder32_share_arbiter #(
    .NUM_REQ (N),
    .WIDTH   (W),
    .ID_W    (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_id    (rsp_id)
`ifdef ADDER32_ARB_OVF_EN
    ,
    .rsp_ovf   (rsp_ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic c);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_cin[i]      = c;
  endtask

  logic [63:0] q[$];

  function automatic logic [63:0] pack(input logic [1:0] id,
                                       input logic ov, input logic co,
                                       input logic [W-1:0] s);
    return {27'd0, ov, id, co, s};
  endfunction

  initial begin
    int order[5];
    int pops;
    int cyc;
    logic [W-1:0] a, b, s;
    logic c, co, ov;
    logic [63:0] e;
    order = '{0, 1, 2, 3, 0};

    // reset state with requests pending
    req_valid = 4'hF;
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_valid", 64'(rsp_valid), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_sum", 64'(rsp_sum), 64'd0);
    req_valid = '0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", 64'(req_ready), 64'd0);

    // single add with carry out
    rsp_ready = 1'b1;
    set_req(0, 32'hFFFF_FFFF, 32'h1, 1'b0);
    req_valid = 4'b0001;
    @(negedge clk);
    chk("single_rdy", 64'(req_ready), 64'h1);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("single_v", 64'(rsp_valid), 64'd1);
    chk("single_sum", 64'(rsp_sum), 64'h0);
    chk("single_co", 64'(rsp_cout), 64'd1);
    chk("single_id", 64'(rsp_id), 64'd0);

    // carry-in, rr_ptr=1 so requester 2 found by search
    set_req(2, 32'h7FFF_FFFF, 32'h0, 1'b1);
    req_valid = 4'b0100;
    @(negedge clk);
    chk("cin_rdy", 64'(req_ready), 64'h4);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("cin_sum", 64'(rsp_sum), 64'h8000_0000);
    chk("cin_co", 64'(rsp_cout), 64'd0);
    chk("cin_id", 64'(rsp_id), 64'd2);
`ifdef ADDER32_ARB_OVF_EN
    chk("cin_ovf", 64'(rsp_ovf), 64'd1);
`endif
    tick();
    @(negedge clk);
    chk("drain", 64'(rsp_valid), 64'd0);

    // wrap: rr_ptr=3, grant 3, then pointer returns to 0
    for (int i = 0; i < N; i++) set_req(i, 32'(i * 16), 32'h1, 1'b0);
    req_valid = 4'b1000;
    @(negedge clk);
    chk("wrap_rdy", 64'(req_ready), 64'h8);
    tick();

    // round robin with all requesters valid
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rr_rdy", 64'(req_ready), 64'(1 << order[k]));
      chk("rr_id", 64'(rsp_id), 64'((k == 0) ? 3 : order[k-1]));
      chk("rr_valid", 64'(rsp_valid), 64'd1);
      tick();
    end
    @(negedge clk);
    chk("rr_last_id", 64'(rsp_id), 64'd0);
    chk("rr_last_sum", 64'(rsp_sum), 64'h1);

    // backpressure for three cycles
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_rdy", 64'(req_ready), 64'd0);
      chk("bp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_id", 64'(rsp_id), 64'd0);
      chk("bp_sum", 64'(rsp_sum), 64'h1);
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_rdy", 64'(req_ready), 64'h2);
    tick();
    @(negedge clk);
    chk("b2b_id", 64'(rsp_id), 64'd1);
    chk("b2b_sum", 64'(rsp_sum), 64'h11);

    // asynchronous reset while FULL
    rsp_ready = 1'b0;
    req_valid = '0;
    tick();
    #2;
    chk("pre_rst_valid", 64'(rsp_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("async_valid", 64'(rsp_valid), 64'd0);
    chk("async_sum", 64'(rsp_sum), 64'd0);
    chk("async_id", 64'(rsp_id), 64'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rdy", 64'(req_ready), 64'd0);
    chk("post_rst_valid", 64'(rsp_valid), 64'd0);
    req_valid = 4'hF;
    #1;
    chk("post_rst_ptr", 64'(req_ready), 64'h1);
    req_valid = '0;
    tick();

    // random traffic against a handshake scoreboard
    pops = 0;
    cyc  = 0;
    while (pops < 1000 && cyc < 20000) begin
      cyc++;
      req_valid = 4'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        a = $urandom;
        b = $urandom;
        if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFF;
        set_req(i, a, b, 1'($urandom));
      end
      @(negedge clk);
      chk("rnd_onehot", 64'($countones(req_ready) <= 1 &&
          (req_ready & ~req_valid) == 0), 64'd1);
      if (rsp_valid && rsp_ready) begin
`ifdef ADDER32_ARB_OVF_EN
        ov = rsp_ovf;
`else
        ov = 1'b0;
`endif
        if (q.size() == 0) begin
          chk("rnd_unexpected", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          chk("rnd_result", pack(rsp_id, ov, rsp_cout, rsp_sum), e);
        end
        pops++;
      end
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          a = req_a[i*W +: W];
          b = req_b[i*W +: W];
          c = req_cin[i];
          {co, s} = {1'b0, a} + {1'b0, b} + 33'(c);
`ifdef ADDER32_ARB_OVF_EN
          ov = (a[31] == b[31]) && (s[31] != a[31]);
`else
          ov = 1'b0;
`endif
          q.push_back(pack(2'(i), ov, co, s));
        end
      end
      tick();
    end
    chk("rnd_count", 64'(pops >= 1000), 64'd1);

    // drain anything still in flight
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (rsp_valid && q.size() != 0) begin
`ifdef ADDER32_ARB_OVF_EN
        ov = rsp_ovf;
`else
        ov = 1'b0;
`endif
        e = q.pop_front();
        chk("drain_result", pack(rsp_id, ov, rsp_cout, rsp_sum), e);
      end
      tick();
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
    chk("drain_valid", 64'(rsp_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
